// File: rtl/product_accumulator.sv
// Frame accumulator: sums unsigned 16-bit products per frame with saturation,
// counts beats, and holds the registered result until downstream consumes it.
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next, acc_base;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_base;
  logic             ovf_reg, ovf_next, ovf_base;
  logic [ACC_W:0]   sum_wide;
  logic             accept;

  logic [ACC_W-1:0] out_sum_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic             out_ovf_reg;

  assign in_ready  = rst_n && (state_reg != HOLD);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid && in_ready;
  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    // A beat accepted in IDLE starts a fresh frame from a zero base.
    acc_base   = (state_reg == IDLE) ? '0   : acc_reg;
    cnt_base   = (state_reg == IDLE) ? '0   : cnt_reg;
    ovf_base   = (state_reg == IDLE) ? 1'b0 : ovf_reg;
    sum_wide   = {1'b0, acc_base} + (ACC_W+1)'(in_data);
    case (state_reg)
      IDLE, ACC: begin
        if (accept) begin
          acc_next   = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
          ovf_next   = ovf_base | sum_wide[ACC_W];
          cnt_next   = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_W'(1);
          state_next = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      // Result registers capture the final values on the last-beat edge only.
      if (accept && in_last) begin
        out_sum_reg   <= acc_next;
        out_count_reg <= cnt_next;
        out_ovf_reg   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed frame table, reset corner cases,
// and random frames checked against an arithmetic frame model.
module tb_product_accumulator;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;
  localparam longint ACC_MAXV = (64'd1 << ACC_W) - 1;
  localparam int CNT_MAXV = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int failures = 0;

  logic [15:0] beat_q[$];

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    int          gap;
    int          hold;
    logic [31:0] e_sum;
    logic [31:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[11];

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives the beats in beat_q as one frame, then exercises HOLD back-pressure
  // and the bubble edge that leaves HOLD.
  task automatic run_frame(input int gap, input int hold_cyc, input logic [31:0] e_sum,
                           input logic [31:0] e_cnt, input logic e_ovf, input string tag);
    for (int i = 0; i < beat_q.size(); i++) begin
      in_valid  = 1'b1;
      in_data   = beat_q[i];
      in_last   = (i == beat_q.size() - 1);
      out_ready = 1'($urandom_range(0, 1));
      chk({tag, " in_ready_beat"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i != beat_q.size() - 1) repeat (gap) tick();
    end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_sum"},   32'(out_sum),   e_sum);
    chk({tag, " out_count"}, 32'(out_count), e_cnt);
    chk({tag, " out_ovf"},   32'(out_ovf),   32'(e_ovf));
    chk({tag, " in_ready_hold"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold_cyc; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_last   = 1'b1;
      tick();
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_sum"},   32'(out_sum),   e_sum);
      chk({tag, " hold_count"}, 32'(out_count), e_cnt);
      chk({tag, " hold_ready"}, 32'(in_ready),  32'd0);
    end
    // A beat offered on the leaving edge must not be taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = 16'h1234;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    chk({tag, " leave_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " leave_ready"}, 32'(in_ready),  32'd1);
    chk({tag, " keep_sum"},    32'(out_sum),   e_sum);
    chk({tag, " keep_count"},  32'(out_count), e_cnt);
    $display("frame %s beats=%0d sum=%0h count=%0d ovf=%0b", tag, beat_q.size(),
             out_sum, out_count, out_ovf);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " rst_sum"},   32'(out_sum),   32'd0);
    chk({tag, " rst_count"}, 32'(out_count), 32'd0);
    chk({tag, " rst_ovf"},   32'(out_ovf),   32'd0);
    chk({tag, " rst_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " rst_ready"}, 32'(in_ready),  32'd0);
  endtask

  initial begin
    longint total;
    int     n;
    logic [31:0] e_sum, e_cnt;
    logic   e_ovf;

    vecs[0]  = '{3,   16'd100,   16'd100, 0, 0, 32'd600,      32'd3,   1'b0};
    vecs[1]  = '{1,   16'hFFFF,  16'd0,   0, 5, 32'd65535,    32'd1,   1'b0};
    vecs[2]  = '{300, 16'hFFFF,  16'd0,   0, 1, 32'hFFFFFF,   32'd255, 1'b1};
    vecs[3]  = '{1,   16'd1,     16'd0,   0, 0, 32'd1,        32'd1,   1'b0};
    vecs[4]  = '{2,   16'd5,     16'd2,   4, 2, 32'd12,       32'd2,   1'b0};
    vecs[5]  = '{1,   16'd1,     16'd0,   0, 0, 32'd1,        32'd1,   1'b0};
    vecs[6]  = '{4,   16'd0,     16'd0,   1, 1, 32'd0,        32'd4,   1'b0};
    vecs[7]  = '{256, 16'hFFFF,  16'd0,   0, 0, 32'hFFFF00,   32'd255, 1'b0};
    vecs[8]  = '{257, 16'hFFFF,  16'd0,   0, 0, 32'hFFFFFF,   32'd255, 1'b1};
    vecs[9]  = '{255, 16'd1,     16'd0,   0, 0, 32'd255,      32'd255, 1'b0};
    vecs[10] = '{254, 16'd1,     16'd0,   0, 0, 32'd254,      32'd254, 1'b0};

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check_zero("init");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      beat_q.delete();
      for (int i = 0; i < vecs[v].n; i++)
        beat_q.push_back(16'(vecs[v].base + 16'(i) * vecs[v].step));
      run_frame(vecs[v].gap, vecs[v].hold, vecs[v].e_sum, vecs[v].e_cnt,
                vecs[v].e_ovf, $sformatf("vec%0d", v));
    end

    // Reset mid-frame: two beats accepted, then asynchronous clear.
    in_valid = 1'b1; in_data = 16'd50; tick();
    in_data = 16'd60; tick();
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'd3;
    #2 rst_n = 1'b0;
    #1 check_zero("midframe");
    tick();
    check_zero("midframe_held");
    #2 rst_n = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    beat_q.delete(); beat_q.push_back(16'd9);
    run_frame(0, 0, 32'd9, 32'd1, 1'b0, "after_rst");

    // Reset while holding a result.
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'd77; tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("pre_rst_hold valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("hold");
    #2 rst_n = 1'b1;
    tick();

    // Random frames against the arithmetic model.
    for (int f = 0; f < 40; f++) begin
      beat_q.delete();
      total = 0;
      if ($urandom_range(0, 6) == 0) begin
        n = $urandom_range(240, 300);
        for (int i = 0; i < n; i++) beat_q.push_back(16'($urandom_range(50000, 65535)));
      end else begin
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) beat_q.push_back(16'($urandom));
      end
      foreach (beat_q[i]) total += longint'(beat_q[i]);
      e_ovf = (total > ACC_MAXV);
      e_sum = e_ovf ? 32'(ACC_MAXV) : 32'(total);
      e_cnt = (n > CNT_MAXV) ? 32'(CNT_MAXV) : 32'(n);
      run_frame($urandom_range(0, 2), $urandom_range(0, 3), e_sum, e_cnt, e_ovf,
                $sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
